// File: rtl/mac_ctrl_fsm_pkg.sv
// Shared types for the MAC job controller: FSM state, latched job config, launch pulses.
// Config field widths match the default address/counter widths of the controller.
package mac_ctrl_package;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SHIFT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  a_addr;
    logic [ADDR_W-1:0]  b_addr;
    logic [ADDR_W-1:0]  c_addr;
    logic [CNT_W-1:0]   len;
    logic [SHIFT_W-1:0] shift;
    logic               simple_mul;
  } job_cfg_t;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic eng;
  } launch_t;

  function automatic launch_t launch_all();
    launch_t l;
    l = '{a: 1'b1, b: 1'b1, c: 1'b1, eng: 1'b1};
    return l;
  endfunction

endpackage

// File: rtl/mac_ctrl_fsm_if.sv
// Register-file/streamer/engine side bundle of the MAC job controller.
// master = controller, slave = surrounding slave + streamer + engine.
interface mac_ctrl_fsm_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  clear_i;
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] cfg_a_addr_i;
  logic [ADDR_WIDTH-1:0] cfg_b_addr_i;
  logic [ADDR_WIDTH-1:0] cfg_c_addr_i;
  logic [CNT_WIDTH-1:0]  cfg_len_i;
  logic [4:0]            cfg_shift_i;
  logic                  cfg_simple_mul_i;
  logic                  src_a_ready_i;
  logic                  src_b_ready_i;
  logic                  sink_c_ready_i;
  logic                  sink_c_done_i;
  logic                  c_hs_i;

  logic                  strm_a_start_o;
  logic                  strm_b_start_o;
  logic                  strm_c_start_o;
  logic [ADDR_WIDTH-1:0] strm_a_addr_o;
  logic [ADDR_WIDTH-1:0] strm_b_addr_o;
  logic [ADDR_WIDTH-1:0] strm_c_addr_o;
  logic [CNT_WIDTH-1:0]  strm_trans_size_o;
  logic                  eng_start_o;
  logic                  eng_clear_o;
  logic [4:0]            eng_shift_o;
  logic                  eng_simple_mul_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic [CNT_WIDTH-1:0]  out_cnt_o;

  modport master (
    input  clear_i, start_i, cfg_a_addr_i, cfg_b_addr_i, cfg_c_addr_i, cfg_len_i,
           cfg_shift_i, cfg_simple_mul_i, src_a_ready_i, src_b_ready_i,
           sink_c_ready_i, sink_c_done_i, c_hs_i,
    output strm_a_start_o, strm_b_start_o, strm_c_start_o, strm_a_addr_o,
           strm_b_addr_o, strm_c_addr_o, strm_trans_size_o, eng_start_o,
           eng_clear_o, eng_shift_o, eng_simple_mul_o, busy_o, done_o, err_o,
           out_cnt_o
  );

  modport slave (
    output clear_i, start_i, cfg_a_addr_i, cfg_b_addr_i, cfg_c_addr_i, cfg_len_i,
           cfg_shift_i, cfg_simple_mul_i, src_a_ready_i, src_b_ready_i,
           sink_c_ready_i, sink_c_done_i, c_hs_i,
    input  strm_a_start_o, strm_b_start_o, strm_c_start_o, strm_a_addr_o,
           strm_b_addr_o, strm_c_addr_o, strm_trans_size_o, eng_start_o,
           eng_clear_o, eng_shift_o, eng_simple_mul_o, busy_o, done_o, err_o,
           out_cnt_o
  );
endinterface

// File: rtl/mac_ctrl_fsm.sv
// MAC job controller: latches config on start, launches streamers+engine once all three
// generators are ready, counts C outputs and pulses done; all outputs registered.
module mac_ctrl_fsm
  import mac_ctrl_package::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic           clk_i,
  input logic           rst_i,
  mac_ctrl_fsm_if.master bus
);

  state_e         state_q, state_d;
  job_cfg_t       cfg_q, cfg_d;
  launch_t        launch_q, launch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           sink_fin_q, sink_fin_d;
  logic           err_q, err_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           eng_clear_q, eng_clear_d;

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    launch_d    = '0;
    cnt_d       = cnt_q;
    sink_fin_d  = sink_fin_q;
    err_d       = err_q;
    done_d      = 1'b0;
    eng_clear_d = 1'b0;

    if (bus.clear_i) begin
      // Soft clear aborts any job and beats every other event this cycle.
      state_d     = ST_IDLE;
      cfg_d       = '0;
      cnt_d       = '0;
      sink_fin_d  = 1'b0;
      err_d       = 1'b0;
      eng_clear_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            cfg_d.a_addr     = ADDR_W'(bus.cfg_a_addr_i);
            cfg_d.b_addr     = ADDR_W'(bus.cfg_b_addr_i);
            cfg_d.c_addr     = ADDR_W'(bus.cfg_c_addr_i);
            cfg_d.len        = CNT_W'(bus.cfg_len_i);
            cfg_d.shift      = bus.cfg_shift_i;
            cfg_d.simple_mul = bus.cfg_simple_mul_i;
            cnt_d            = '0;
            sink_fin_d       = 1'b0;
            err_d            = 1'b0;
            if (bus.cfg_len_i == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          if (bus.src_a_ready_i && bus.src_b_ready_i && bus.sink_c_ready_i) begin
            launch_d = launch_all();
            state_d  = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.c_hs_i) begin
            if (cnt_q == cfg_q.len) err_d = 1'b1;
            else                    cnt_d = cnt_q + 1'b1;
          end
          if (bus.sink_c_done_i) sink_fin_d = 1'b1;
          // Completion uses this cycle's events so done lands one cycle after the last one.
          if ((cnt_d == cfg_q.len) && sink_fin_d) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      launch_q    <= '0;
      cnt_q       <= '0;
      sink_fin_q  <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      eng_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      launch_q    <= launch_d;
      cnt_q       <= cnt_d;
      sink_fin_q  <= sink_fin_d;
      err_q       <= err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      eng_clear_q <= eng_clear_d;
    end
  end

  assign bus.strm_a_start_o    = launch_q.a;
  assign bus.strm_b_start_o    = launch_q.b;
  assign bus.strm_c_start_o    = launch_q.c;
  assign bus.eng_start_o       = launch_q.eng;
  assign bus.strm_a_addr_o     = ADDR_WIDTH'(cfg_q.a_addr);
  assign bus.strm_b_addr_o     = ADDR_WIDTH'(cfg_q.b_addr);
  assign bus.strm_c_addr_o     = ADDR_WIDTH'(cfg_q.c_addr);
  assign bus.strm_trans_size_o = CNT_WIDTH'(cfg_q.len);
  assign bus.eng_shift_o       = cfg_q.shift;
  assign bus.eng_simple_mul_o  = cfg_q.simple_mul;
  assign bus.eng_clear_o       = eng_clear_q;
  assign bus.busy_o            = busy_q;
  assign bus.done_o            = done_q;
  assign bus.err_o             = err_q;
  assign bus.out_cnt_o         = CNT_WIDTH'(cnt_q);

endmodule

// File: tb/tb_mac_ctrl_fsm.sv
// Directed bench for mac_ctrl_fsm: stimulus pushes expected launch/done/clear events,
// a negedge monitor pops and compares whenever the controller emits one.
module tb_mac_ctrl_fsm;

  localparam int K_LAUNCH = 0;
  localparam int K_DONE   = 1;
  localparam int K_CLR    = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] a_addr;
    logic [15:0] len;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  mac_ctrl_fsm_if #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) bus ();

  mac_ctrl_fsm #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [31:0] a,
                      input logic [15:0] len, input logic [15:0] cnt, input logic err);
    exp_t e;
    e.kind = kind; e.cyc = c; e.a_addr = a; e.len = len; e.cnt = cnt; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a start with derived B/C bases; returns the edge that samples it.
  task automatic start_job(input logic [31:0] a, input logic [15:0] len, output int e);
    bus.cfg_a_addr_i     = a;
    bus.cfg_b_addr_i     = a + 32'h100;
    bus.cfg_c_addr_i     = a + 32'h200;
    bus.cfg_len_i        = len;
    bus.cfg_shift_i      = 5'd3;
    bus.cfg_simple_mul_i = 1'b1;
    bus.start_i          = 1'b1;
    e = cyc + 1;
  endtask

  // Monitor
  logic [3:0] starts;
  int         obs_kind;
  exp_t       cur;

  always @(negedge clk) begin
    if (!rst) begin
      starts = {bus.strm_a_start_o, bus.strm_b_start_o, bus.strm_c_start_o, bus.eng_start_o};
      if (starts != 4'h0 || bus.done_o || bus.eng_clear_o) begin
        obs_kind = bus.done_o ? K_DONE : (bus.eng_clear_o ? K_CLR : K_LAUNCH);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d starts=%b at cycle %0d, expected no event",
                   obs_kind, starts, cyc);
        end else begin
          cur = exp_q.pop_front();
          chk("event_kind", 64'(obs_kind), 64'(cur.kind));
          chk("event_cycle", 64'(cyc), 64'(cur.cyc));
          if (cur.kind == K_LAUNCH) begin
            chk("launch_pulses", 64'(starts), 64'h0f);
            chk("launch_a_addr", 64'(bus.strm_a_addr_o), 64'(cur.a_addr));
            chk("launch_c_addr", 64'(bus.strm_c_addr_o), 64'(cur.a_addr + 32'h200));
            chk("launch_size", 64'(bus.strm_trans_size_o), 64'(cur.len));
            chk("launch_shift", 64'(bus.eng_shift_o), 64'd3);
          end else if (cur.kind == K_DONE) begin
            chk("done_starts", 64'(starts), 64'h0);
            chk("done_out_cnt", 64'(bus.out_cnt_o), 64'(cur.cnt));
            chk("done_err", 64'(bus.err_o), 64'(cur.err));
            chk("done_busy", 64'(bus.busy_o), 64'd1);
          end else begin
            chk("clear_busy", 64'(bus.busy_o), 64'd0);
            chk("clear_out_cnt", 64'(bus.out_cnt_o), 64'd0);
            chk("clear_a_addr", 64'(bus.strm_a_addr_o), 64'd0);
            chk("clear_done", 64'(bus.done_o), 64'd0);
          end
        end
      end
    end
  end

  int e;

  initial begin
    bus.clear_i = 0; bus.start_i = 0; bus.cfg_a_addr_i = 0; bus.cfg_b_addr_i = 0;
    bus.cfg_c_addr_i = 0; bus.cfg_len_i = 0; bus.cfg_shift_i = 0; bus.cfg_simple_mul_i = 0;
    bus.src_a_ready_i = 0; bus.src_b_ready_i = 0; bus.sink_c_ready_i = 0;
    bus.sink_c_done_i = 0; bus.c_hs_i = 0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_out_cnt", 64'(bus.out_cnt_o), 64'd0);
    chk("rst_a_addr", 64'(bus.strm_a_addr_o), 64'd0);
    chk("rst_size", 64'(bus.strm_trans_size_o), 64'd0);

    // Basic job, len 4, all readies high
    bus.src_a_ready_i = 1; bus.src_b_ready_i = 1; bus.sink_c_ready_i = 1;
    start_job(32'h1000, 16'd4, e);
    push(K_LAUNCH, e + 1, 32'h1000, 16'd4, 16'd0, 1'b0);
    tick(1); bus.start_i = 0;
    tick(1);
    bus.c_hs_i = 1; tick(4); bus.c_hs_i = 0;
    chk("basic_cnt_before_done", 64'(bus.out_cnt_o), 64'd4);
    bus.sink_c_done_i = 1;
    push(K_DONE, cyc + 1, 32'h1000, 16'd4, 16'd4, 1'b0);
    tick(1); bus.sink_c_done_i = 0;
    tick(2);

    // Staggered ready: sink low for 5 LAUNCH cycles, then hs and sink done together
    bus.sink_c_ready_i = 0;
    start_job(32'h2000, 16'd1, e);
    push(K_LAUNCH, e + 6, 32'h2000, 16'd1, 16'd0, 1'b0);
    tick(1); bus.start_i = 0;
    tick(5);
    bus.sink_c_ready_i = 1;
    tick(1);
    bus.c_hs_i = 1; bus.sink_c_done_i = 1;
    push(K_DONE, e + 7, 32'h2000, 16'd1, 16'd1, 1'b0);
    tick(1); bus.c_hs_i = 0; bus.sink_c_done_i = 0;
    tick(2);

    // Zero length: done straight away, busy for that cycle only
    start_job(32'h3000, 16'd0, e);
    push(K_DONE, e, 32'h3000, 16'd0, 16'd0, 1'b0);
    tick(1); bus.start_i = 0;
    chk("zero_busy_in_done", 64'(bus.busy_o), 64'd1);
    tick(1);
    chk("zero_busy_after", 64'(bus.busy_o), 64'd0);
    tick(1);

    // Ordering: sink done before the 3rd of 3 outputs
    start_job(32'h4000, 16'd3, e);
    push(K_LAUNCH, e + 1, 32'h4000, 16'd3, 16'd0, 1'b0);
    tick(1); bus.start_i = 0;
    tick(1);
    bus.c_hs_i = 1; tick(2); bus.c_hs_i = 0;
    bus.sink_c_done_i = 1; tick(1); bus.sink_c_done_i = 0;
    tick(1);
    chk("order_cnt_waiting", 64'(bus.out_cnt_o), 64'd2);
    chk("order_busy_waiting", 64'(bus.busy_o), 64'd1);
    bus.c_hs_i = 1;
    push(K_DONE, e + 6, 32'h4000, 16'd3, 16'd3, 1'b0);
    tick(1); bus.c_hs_i = 0;
    tick(2);

    // Overflow plus ignored start during RUN
    start_job(32'h5000, 16'd4, e);
    push(K_LAUNCH, e + 1, 32'h5000, 16'd4, 16'd0, 1'b0);
    tick(1); bus.start_i = 0;
    tick(1);
    bus.c_hs_i = 1; tick(5); bus.c_hs_i = 0;
    chk("ovf_cnt_held", 64'(bus.out_cnt_o), 64'd4);
    chk("ovf_err", 64'(bus.err_o), 64'd1);
    bus.cfg_a_addr_i = 32'hDEAD0000; bus.cfg_len_i = 16'd7; bus.start_i = 1;
    tick(1); bus.start_i = 0;
    chk("run_start_a_addr", 64'(bus.strm_a_addr_o), 64'h5000);
    chk("run_start_size", 64'(bus.strm_trans_size_o), 64'd4);
    chk("run_start_busy", 64'(bus.busy_o), 64'd1);
    bus.sink_c_done_i = 1;
    push(K_DONE, cyc + 1, 32'h5000, 16'd4, 16'd4, 1'b1);
    tick(1); bus.sink_c_done_i = 0;
    tick(2);

    // Abort by clear during RUN; late hs/done in IDLE must be ignored
    start_job(32'h6000, 16'd2, e);
    push(K_LAUNCH, e + 1, 32'h6000, 16'd2, 16'd0, 1'b0);
    tick(1); bus.start_i = 0;
    tick(1);
    bus.c_hs_i = 1; tick(1); bus.c_hs_i = 0;
    bus.clear_i = 1;
    push(K_CLR, e + 3, 32'h0, 16'd0, 16'd0, 1'b0);
    tick(1); bus.clear_i = 0;
    chk("abort_err_cleared", 64'(bus.err_o), 64'd0);
    tick(1);
    bus.c_hs_i = 1; bus.sink_c_done_i = 1;
    tick(1); bus.c_hs_i = 0; bus.sink_c_done_i = 0;
    tick(2);
    chk("idle_hs_ignored", 64'(bus.out_cnt_o), 64'd0);

    // Async reset mid-LAUNCH
    bus.sink_c_ready_i = 0;
    start_job(32'h7000, 16'd5, e);
    tick(1); bus.start_i = 0;
    tick(1);
    chk("launch_busy", 64'(bus.busy_o), 64'd1);
    chk("launch_a_latched", 64'(bus.strm_a_addr_o), 64'h7000);
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.busy_o), 64'd0);
    chk("arst_a_addr", 64'(bus.strm_a_addr_o), 64'd0);
    chk("arst_size", 64'(bus.strm_trans_size_o), 64'd0);
    tick(1);
    rst = 1'b0;
    bus.sink_c_ready_i = 1;
    tick(4);

    chk("pending_events", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
